// File: rtl/prog_loader.sv
// Boot loader: parses an A5/len/words/csum byte frame, writes 19-bit words to imem from addr 0, releases CPU on success.
// Latency: imem write strobe one cycle after the third word byte is accepted; cpu_run/load_error one cycle after the csum byte.
// Backpressure: rx_ready is registered, high from IDLE through CSUM and dropped for good in DONE/ERROR.
module prog_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0] imem_wdata,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  cpu_run,
    output logic                  load_error
);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_W0, S_W1, S_W2, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t state, state_nxt;

    logic                  acc;
    logic [7:0]            len_hi_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [2:0]            b0_q;
    logic [7:0]            b1_q;
    logic [7:0]            csum_q;
    logic [16:0]           n_rx;
    logic [16:0]           n_max;
    logic [ADDR_WIDTH:0]   count_inc;
    logic                  last_word;

    assign acc       = rx_valid && rx_ready;
    assign n_rx      = {1'b0, len_hi_q, rx_data};
    assign n_max     = 17'd1 << ADDR_WIDTH;
    assign count_inc = word_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign last_word = (count_inc == len_q);

    assign cpu_run    = (state == S_DONE);
    assign load_error = (state == S_ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (acc) begin
            case (state)
                S_IDLE:   if (rx_data == 8'hA5) state_nxt = S_LEN_HI;
                S_LEN_HI: state_nxt = S_LEN_LO;
                S_LEN_LO: begin
                    // Length is checked before any write, so the address never wraps.
                    if (n_rx > n_max)       state_nxt = S_ERROR;
                    else if (n_rx == 17'd0) state_nxt = S_CSUM;
                    else                    state_nxt = S_W0;
                end
                S_W0:     state_nxt = (rx_data[7:3] != 5'd0) ? S_ERROR : S_W1;
                S_W1:     state_nxt = S_W2;
                S_W2:     state_nxt = last_word ? S_CSUM : S_W0;
                S_CSUM:   state_nxt = (rx_data == csum_q) ? S_DONE : S_ERROR;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            len_hi_q   <= '0;
            len_q      <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            csum_q     <= '0;
        end else begin
            rx_ready <= !(state_nxt == S_DONE || state_nxt == S_ERROR);
            imem_we  <= 1'b0;
            if (acc) begin
                case (state)
                    S_IDLE:   if (rx_data == 8'hA5) csum_q <= 8'h00;
                    S_LEN_HI: len_hi_q <= rx_data;
                    S_LEN_LO: len_q <= n_rx[ADDR_WIDTH:0];
                    S_W0: begin
                        b0_q   <= rx_data[2:0];
                        csum_q <= csum_q ^ rx_data;
                    end
                    S_W1: begin
                        b1_q   <= rx_data;
                        csum_q <= csum_q ^ rx_data;
                    end
                    S_W2: begin
                        csum_q     <= csum_q ^ rx_data;
                        imem_we    <= 1'b1;
                        imem_addr  <= word_count[ADDR_WIDTH-1:0];
                        imem_wdata <= {b0_q, b1_q, rx_data};
                        word_count <= count_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
